// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and constant helpers for the mux select sequencer.
package mux_select_sequencer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // First select index presented in a frame.
  function automatic int unsigned start_idx(input int unsigned width, input bit lsb_first);
    return lsb_first ? 0 : width - 1;
  endfunction

  // Select index whose terminal hold cycle ends the frame.
  function automatic int unsigned last_idx(input int unsigned width, input bit lsb_first);
    return lsb_first ? width - 1 : 0;
  endfunction

endpackage

// File: rtl/mux_select_sequencer_hold_counter.sv
// HOLD-cycle prescaler: strobes tc_c on the last cycle of each hold period.
module mux_select_sequencer_hold_counter #(
  parameter int unsigned HOLD = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tc_c,
  output logic tc_next_c
);

  localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tc_c      = (cnt_q == CNT_MAX);
  assign tc_next_c = (cnt_d == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc_c ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Loads a word over valid/ready and steps the downstream 8:1 mux select through
// every index, holding each for HOLD cycles, then pulses done.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned HOLD      = 1,
  parameter bit          LSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic [WIDTH-1:0]         mux_data,
  output logic [$clog2(WIDTH)-1:0] mux_sel,
  output logic                     busy,
  output logic                     sout,
  output logic                     done
);

  localparam int unsigned SEL_W = $clog2(WIDTH);
  localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(WIDTH, LSB_FIRST));
  localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_idx(WIDTH, LSB_FIRST));

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             xfer_c;
  logic             tc_c;
  logic             tc_next_c;

  assign xfer_c = in_valid & ready_q;

  mux_select_sequencer_hold_counter #(
    .HOLD (HOLD)
  ) u_hold_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (state_q == SHIFT),
    .clr       (xfer_c),
    .tc_c      (tc_c),
    .tc_next_c (tc_next_c)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (xfer_c) begin
          data_d  = in_data;
          sel_d   = START;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (tc_c) begin
          if (sel_q == LAST) begin
            // Terminal cycle: return to start rather than wrapping the select.
            done_d = 1'b1;
            sel_d  = START;
            if (xfer_c) begin
              data_d = in_data;
            end else begin
              state_d = IDLE;
            end
          end else begin
            sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d == SHIFT);
    // Ready next cycle when idle or when that cycle will be the frame's terminal hold cycle.
    ready_d = (state_d == IDLE) || ((sel_d == LAST) && tc_next_c);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= START;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign in_ready = ready_q;
  assign mux_data = data_q;
  assign mux_sel  = sel_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sout     = data_q[sel_q];

endmodule

// File: doc/mux_select_sequencer.md
Name: mux_select_sequencer

Overview:
Upstream driver for the 8:1 multiplexer built from 2:1 muxes. It accepts a parallel data word over a valid/ready handshake and holds it on the mux data inputs. It then steps the select lines through every index, holding each index for a programmable number of cycles. This serialises the word through the downstream mux and signals the end of each frame.

Parameters:
WIDTH, 8, data word width and number of mux inputs; must be a power of two, at least 2
SEL_W, 3, select width; equal to log2(WIDTH) and derived, not overridden
HOLD, 1, clock cycles each select value is held; at least 1
LSB_FIRST, 1, 1 steps select from 0 up to WIDTH-1; 0 steps from WIDTH-1 down to 0

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  parallel word to serialise
mux_data  output  WIDTH  registered word, drives the mux data inputs
mux_sel  output  SEL_W  registered select; bit SEL_W-1 drives the mux MSB select
busy  output  1  a frame is in progress
sout  output  1  mux_data[mux_sel], combinational reference copy of the mux output, for self-check
done  output  1  one-cycle pulse after the last index finishes its hold

Behaviour:
- Reset applies on a clk edge while rst_n=0:
  - state IDLE, mux_data=0, hold_cnt=0, busy=0, done=0.
  - mux_sel = start index: 0 when LSB_FIRST=1, WIDTH-1 when LSB_FIRST=0.
  - Reset mid-frame aborts the frame: no done pulse, word discarded.
- IDLE state:
  - in_ready=1, busy=0, mux_sel held at start index.
  - A transfer (in_valid & in_ready) loads mux_data=in_data, mux_sel=start index, hold_cnt=0, and moves to SHIFT.
  - Word loaded at edge N is on mux_data from cycle N+1. First select is valid in that same cycle, so latency is 1 cycle.
- SHIFT state:
  - busy=1.
  - Each cycle, hold_cnt increments. When hold_cnt==HOLD-1, hold_cnt clears and mux_sel steps by +1 (LSB_FIRST=1) or -1 (LSB_FIRST=0).
  - Each index is presented for exactly HOLD cycles; a frame lasts WIDTH*HOLD cycles.
- Last index is WIDTH-1 when LSB_FIRST=1, or 0 when LSB_FIRST=0. At its terminal hold cycle:
  - done is registered high for the next cycle only.
  - mux_sel returns to the start index; it does not wrap through the counter.
  - Without a new transfer: state goes to IDLE, and mux_data keeps the old word until the next load.
- in_ready:
  - 1 in IDLE.
  - 1 during the terminal hold cycle of the last index, for back-to-back frames with no gap.
  - 0 at all other SHIFT cycles. in_data offered while in_ready=0 is ignored (not queued).
- Back-to-back: a transfer in the terminal cycle loads the new word, asserts done for the old frame, and stays in SHIFT at the start index with hold_cnt=0.
- sout is purely combinational from mux_data and mux_sel. It is meaningful only while busy=1.
- in_valid is sampled only when in_ready=1. No other input affects state.
- Select arithmetic is modulo 2^SEL_W and never leaves the range 0..WIDTH-1.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHIFT);
  - the start_idx and last_idx constant functions of WIDTH and LSB_FIRST.
- One natural sub-module: hold_counter. It is a HOLD-cycle prescaler producing a terminal-count strobe.
- Select stepping and the FSM stay in the top level.

Test Plan:
1. Basic frame: LSB_FIRST=1, HOLD=1, load 8'b10100101 at cycle 0.
   -> mux_sel 0..7 over cycles 1..8; sout 1,0,1,0,0,1,0,1; done=1 at cycle 9; busy falls at cycle 9; in_ready=1 in cycle 8.
2. Hold: HOLD=4, same word.
   -> each mux_sel value is stable exactly 4 cycles; done at cycle 33; in_ready low during cycles 1..31.
3. MSB-first: LSB_FIRST=0, HOLD=1, load 8'b00000001.
   -> mux_sel 7..0; sout is 0 for seven cycles, then 1 at cycle 8; done at cycle 9.
4. Back-to-back: in_valid held high with 8'hA5 then 8'h3C.
   -> second word loads in the terminal cycle of the first; mux_sel goes 7 to 0 with no idle gap; done pulses once per frame; no word is dropped.
5. Ignored input: in_valid pulses with 8'hFF at cycle 3 (mid-frame).
   -> mux_data is unchanged; no extra frame follows.
6. Reset mid-frame: rst_n=0 at cycle 4 of a frame.
   -> the next cycle shows mux_sel=0, mux_data=0, busy=0, done=0, in_ready=1; no done pulse ever follows for the aborted frame.
